// File: rtl/sentinel_arb_pkg.sv
// rtl/sentinel_arb_pkg.sv - shared types and constants for the sentinel_arb order-entry merger
//
// Purpose: FSM state enum, source-ID width helper and default sizing constants
// shared by sentinel_arb and rr_pick. No ports.
package sentinel_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_N_SRC      = 4;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_WINDOW_CYC = 1024;
  localparam int DEF_QUOTA_W    = 16;

  // Width of a source index; a single source still needs one bit on the wire.
  function automatic int src_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sentinel_arb_rr_pick.sv
// rtl/sentinel_arb_rr_pick.sv - combinational round-robin priority picker
//
// Purpose: pick the first requester searching upward from last_i+1 (mod N).
// Ports:
//   req_i      in  N     request vector
//   last_i     in  ID_W  index granted last time
//   gnt_oh_o   out N     one-hot pick (all zero when nothing requests)
//   gnt_idx_o  out ID_W  encoded pick
//   any_o      out 1     at least one request present
module rr_pick
  import sentinel_arb_pkg::*;
#(
  parameter int N    = DEF_N_SRC,
  parameter int ID_W = src_id_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  output logic [N-1:0]    gnt_oh_o,
  output logic [ID_W-1:0] gnt_idx_o,
  output logic            any_o
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    gnt_idx_o = '0;
    gnt_oh_o  = '0;
    found     = 1'b0;
    cand      = '0;
    // k runs 1..N so last_i itself is considered last.
    for (int k = 1; k <= N; k++) begin
      cand = ID_W'((int'(last_i) + k) % N);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (found) gnt_oh_o[gnt_idx_o] = 1'b1;
    any_o = found;
  end

endmodule

// File: rtl/sentinel_arb.sv
// rtl/sentinel_arb.sv - packet-atomic quota-limited round-robin stream arbiter
//
// Purpose: merge N_SRC order-entry streams into one, one whole packet per grant,
// with a per-source beat quota per WINDOW_CYC-cycle window.
// Ports:
//   aclk, areset              clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast  per-source input streams (source i at slice i)
//   s_axis_tready              per-source ready (only the granted source, only in BUSY)
//   m_axis_tdata/tvalid/tlast  merged output, one-entry register stage
//   m_axis_tuser               source ID of the current output beat
//   m_axis_tready              downstream ready
//   cfg_en                     allow new grants
//   cfg_quota                  beats per window per source, 0 = unlimited
//   stat_throttled             source over quota in current window
//   busy                       a packet is granted
module sentinel_arb
  import sentinel_arb_pkg::*;
#(
  parameter int N_SRC      = DEF_N_SRC,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WINDOW_CYC = DEF_WINDOW_CYC,
  parameter int QUOTA_W    = DEF_QUOTA_W
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_SRC*DATA_W-1:0]    s_axis_tdata,
  input  logic [N_SRC-1:0]           s_axis_tvalid,
  input  logic [N_SRC-1:0]           s_axis_tlast,
  output logic [N_SRC-1:0]           s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [$clog2(N_SRC)-1:0]   m_axis_tuser,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  input  logic                       cfg_en,
  input  logic [N_SRC*QUOTA_W-1:0]   cfg_quota,
  output logic [N_SRC-1:0]           stat_throttled,
  output logic                       busy
);

  localparam int ID_W  = src_id_w(N_SRC);
  localparam int WIN_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d, last_grant_q, last_grant_d;
  logic [N_SRC-1:0]   grant_oh_q, grant_oh_d;
  logic               tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_W-1:0]  tdata_q, tdata_d;
  logic [ID_W-1:0]    tuser_q, tuser_d;
  logic [QUOTA_W-1:0] beat_cnt_q [N_SRC];
  logic [QUOTA_W-1:0] beat_cnt_d [N_SRC];
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;

  logic [N_SRC-1:0]   throttled, elig, pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any, out_ready, accept, wrap;

  always_comb begin
    throttled = '0;
    for (int i = 0; i < N_SRC; i++) begin
      throttled[i] = (cfg_quota[i*QUOTA_W +: QUOTA_W] != '0) &&
                     (beat_cnt_q[i] >= cfg_quota[i*QUOTA_W +: QUOTA_W]);
    end
  end

  assign elig = s_axis_tvalid & ~throttled & {N_SRC{cfg_en}};

  rr_pick #(.N(N_SRC), .ID_W(ID_W)) u_pick (
    .req_i     (elig),
    .last_i    (last_grant_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign out_ready = !tvalid_q || m_axis_tready;
  assign accept    = (state_q == BUSY) && out_ready && s_axis_tvalid[grant_q];
  assign wrap      = (win_cnt_q == WIN_LAST);

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = BUSY;
      BUSY:    if (accept && s_axis_tlast[grant_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy          = (state_q == BUSY);
    s_axis_tready = (busy && out_ready) ? grant_oh_q : '0;
  end

  // Grant, output stage and quota/window counters
  always_comb begin
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    if (state_q == IDLE && pick_any) begin
      grant_d      = pick_idx;
      grant_oh_d   = pick_oh;
      last_grant_d = pick_idx;
    end

    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    if (accept) begin
      tvalid_d = 1'b1;
      tlast_d  = s_axis_tlast[grant_q];
      tdata_d  = s_axis_tdata[grant_q*DATA_W +: DATA_W];
      tuser_d  = grant_q;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    win_cnt_d = wrap ? '0 : win_cnt_q + 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      beat_cnt_d[i] = wrap ? '0 : beat_cnt_q[i];
      if (accept && grant_q == ID_W'(i)) begin
        // A beat on the wrap cycle belongs to the new window.
        if (wrap) beat_cnt_d[i] = QUOTA_W'(1);
        else if (beat_cnt_q[i] != '1) beat_cnt_d[i] = beat_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= ID_W'(N_SRC - 1);
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= '0;
      win_cnt_q    <= '0;
      for (int i = 0; i < N_SRC; i++) beat_cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      tuser_q      <= tuser_d;
      win_cnt_q    <= win_cnt_d;
      for (int i = 0; i < N_SRC; i++) beat_cnt_q[i] <= beat_cnt_d[i];
    end
  end

  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tuser   = tuser_q;
  assign stat_throttled = throttled;

endmodule
